// File: rtl/mem_port_arb.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arb
//  Purpose  : Two-requester round-robin arbiter and clear sequencer for the
//             single read/write port (port 0) of a 2R/1W memory. After reset,
//             or when clr is sampled in RUN, every word is swept to INIT_VAL
//             before any access is granted. Read data is registered and
//             returned one cycle after the grant.
//  Ports    : clk, rst            clock, asynchronous active-high reset
//             clr, busy           clear-sweep request / sweep in progress
//             rK_valid/we/addr/   requester K request, direction, address,
//             rK_wdata/ready      write data, grant (same-cycle)
//             rK_rvalid/rdata     requester K registered read response
//             m_addr/m_in/m_we    memory port-0 drive
//             m_out               memory port-0 read data (combinational)
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arb #(
   parameter int               WIDTH    = 32,
   parameter int               WORD     = 1024,
   parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   output logic             busy,
   input  logic             r0_valid,
   input  logic             r0_we,
   input  logic [31:0]      r0_addr,
   input  logic [WIDTH-1:0] r0_wdata,
   output logic             r0_ready,
   output logic             r0_rvalid,
   output logic [WIDTH-1:0] r0_rdata,
   input  logic             r1_valid,
   input  logic             r1_we,
   input  logic [31:0]      r1_addr,
   input  logic [WIDTH-1:0] r1_wdata,
   output logic             r1_ready,
   output logic             r1_rvalid,
   output logic [WIDTH-1:0] r1_rdata,
   output logic [31:0]      m_addr,
   output logic [WIDTH-1:0] m_in,
   output logic             m_we,
   input  logic [WIDTH-1:0] m_out
);

   // Sweep counter width; a one-word memory still needs a 1-bit counter.
   localparam int            AW       = (WORD > 1) ? $clog2(WORD) : 1;
   localparam logic [AW-1:0] CNT_LAST = AW'(WORD - 1);

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] cnt, cnt_nxt;
   logic          ptr, ptr_nxt;     // 0: requester 0 preferred on contention
   logic          gnt0, gnt1;

   // ------------------------------------------------------------------------
   // State register: FSM state, sweep counter and round-robin pointer.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= CLEAR;
         cnt   <= '0;
         ptr   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         ptr   <= ptr_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state, grant selection and memory port drive.
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ptr_nxt   = ptr;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      busy      = 1'b0;
      r0_ready  = 1'b0;
      r1_ready  = 1'b0;
      m_we      = 1'b0;
      m_addr    = '0;
      m_in      = '0;

      case (state)
         CLEAR: begin
            // One word written per cycle; requesters are held off and clr
            // has no effect until the sweep is finished.
            busy   = 1'b1;
            m_we   = 1'b1;
            m_addr = 32'(cnt);
            m_in   = INIT_VAL;
            if (cnt == CNT_LAST) begin
               state_nxt = RUN;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + AW'(1);
            end
         end

         RUN: begin
            if (clr) begin
               // A clear request suppresses all grants this cycle and keeps
               // the pointer so fairness resumes where it left off.
               state_nxt = CLEAR;
               cnt_nxt   = '0;
            end else begin
               gnt0 = r0_valid && (!r1_valid || !ptr);
               gnt1 = r1_valid && (!r0_valid ||  ptr);
               if (gnt0) begin
                  r0_ready = 1'b1;
                  m_addr   = r0_addr;
                  m_we     = r0_we;
                  m_in     = r0_wdata;
                  ptr_nxt  = 1'b1;
               end else if (gnt1) begin
                  r1_ready = 1'b1;
                  m_addr   = r1_addr;
                  m_we     = r1_we;
                  m_in     = r1_wdata;
                  ptr_nxt  = 1'b0;
               end
            end
         end

         default: begin
            state_nxt = CLEAR;
            cnt_nxt   = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Read responses: m_out is captured at the grant edge, so a read granted
   // right after a write to the same word sees the freshly written data.
   // rdata holds its value between responses.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r0_rvalid <= 1'b0;
         r0_rdata  <= '0;
         r1_rvalid <= 1'b0;
         r1_rdata  <= '0;
      end else begin
         r0_rvalid <= gnt0 && !r0_we;
         r1_rvalid <= gnt1 && !r1_we;
         if (gnt0 && !r0_we) begin
            r0_rdata <= m_out;
         end
         if (gnt1 && !r1_we) begin
            r1_rdata <= m_out;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arb
//  Purpose  : Directed self-checking bench for mem_port_arb (WORD=16,
//             WIDTH=32). A behavioural memory answers the DUT port; a
//             reference word array and per-requester queues hold the
//             expected read responses.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arb;

   localparam int WIDTH = 32;
   localparam int WORD  = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             clr;
   logic             busy;
   logic             r0_valid, r0_we, r0_ready, r0_rvalid;
   logic [31:0]      r0_addr;
   logic [WIDTH-1:0] r0_wdata, r0_rdata;
   logic             r1_valid, r1_we, r1_ready, r1_rvalid;
   logic [31:0]      r1_addr;
   logic [WIDTH-1:0] r1_wdata, r1_rdata;
   logic [31:0]      m_addr;
   logic [WIDTH-1:0] m_in, m_out;
   logic             m_we;

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] mem     [WORD];   // behavioural memory seen by the DUT
   logic [WIDTH-1:0] exp_mem [WORD];   // expected memory contents
   logic [WIDTH-1:0] q0[$], q1[$];     // expected read data per requester
   logic             pend0 = 1'b0, pend1 = 1'b0;

   mem_port_arb #(.WIDTH(WIDTH), .WORD(WORD), .INIT_VAL('0)) dut (
      .clk(clk), .rst(rst), .clr(clr), .busy(busy),
      .r0_valid(r0_valid), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r0_ready(r0_ready), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
      .r1_valid(r1_valid), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r1_ready(r1_ready), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
      .m_addr(m_addr), .m_in(m_in), .m_we(m_we), .m_out(m_out)
   );

   always #5 clk = ~clk;

   assign m_out = mem[m_addr[3:0]];
   always @(posedge clk) if (m_we) mem[m_addr[3:0]] <= m_in;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Response monitor: checks last cycle's expected response, then records
   // this cycle's grants into the scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         pend0 = 1'b0;
         pend1 = 1'b0;
         q0.delete();
         q1.delete();
      end else begin
         chk("r0_rvalid", r0_rvalid, pend0);
         chk("r1_rvalid", r1_rvalid, pend1);
         if (pend0 && q0.size() > 0) chk("r0_rdata", r0_rdata, q0.pop_front());
         if (pend1 && q1.size() > 0) chk("r1_rdata", r1_rdata, q1.pop_front());
         pend0 = r0_ready && !r0_we;
         pend1 = r1_ready && !r1_we;
         if (pend0) q0.push_back(exp_mem[r0_addr[3:0]]);
         if (pend1) q1.push_back(exp_mem[r1_addr[3:0]]);
         if (r0_ready && r0_we) exp_mem[r0_addr[3:0]] = r0_wdata;
         if (r1_ready && r1_we) exp_mem[r1_addr[3:0]] = r1_wdata;
      end
   end

   // Expects the DUT to be in the first cycle of a sweep at the next negedge.
   task automatic sweep_check(input string tag);
      for (int i = 0; i < WORD; i++) begin
         @(negedge clk);
         chk({tag, "_busy"},   busy,     1);
         chk({tag, "_m_we"},   m_we,     1);
         chk({tag, "_m_addr"}, m_addr,   i);
         chk({tag, "_m_in"},   m_in,     0);
         chk({tag, "_rdy0"},   r0_ready, 0);
         chk({tag, "_rdy1"},   r1_ready, 0);
         cyc();
      end
      @(negedge clk);
      chk({tag, "_busy_end"}, busy, 0);
   endtask

   task automatic clear_exp();
      for (int i = 0; i < WORD; i++) exp_mem[i] = '0;
   endtask

   initial begin
      for (int i = 0; i < WORD; i++) mem[i] = 32'hA5A5_0000 | i;
      clear_exp();
      rst = 1'b1; clr = 1'b0;
      r0_valid = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
      r1_valid = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;

      // ---- reset state ----
      @(negedge clk);
      chk("rst_busy", busy, 1);
      chk("rst_rdy0", r0_ready, 0);
      chk("rst_rdy1", r1_ready, 0);
      chk("rst_rv0", r0_rvalid, 0);
      chk("rst_rd0", r0_rdata, 0);
      chk("rst_rd1", r1_rdata, 0);
      cyc();
      rst = 1'b0;

      // ---- reset sweep, then read back every word ----
      sweep_check("sweep");
      cyc();
      for (int a = 0; a < WORD; a++) begin
         r0_valid = 1; r0_we = 0; r0_addr = a;
         @(negedge clk); chk("rd_all_rdy0", r0_ready, 1);
         cyc();
      end
      r0_valid = 0;

      // ---- single requester: write then read ----
      r0_valid = 1; r0_we = 1; r0_addr = 5; r0_wdata = 32'hDEADBEEF;
      @(negedge clk); chk("single_wr_rdy0", r0_ready, 1); chk("single_wr_mwe", m_we, 1);
      cyc();
      r0_we = 0;
      @(negedge clk); chk("single_rd_rdy0", r0_ready, 1); chk("single_rd_maddr", m_addr, 5);
      cyc();
      r0_valid = 0;
      @(negedge clk); chk("single_rv0", r0_rvalid, 1); chk("single_rd0", r0_rdata, 32'hDEADBEEF);
      cyc();

      // ---- seed addr 1/2; leaves pointer at requester 0 ----
      r0_valid = 1; r0_we = 1; r0_addr = 1; r0_wdata = 32'h11111111;
      @(negedge clk); chk("seed1_rdy0", r0_ready, 1);
      cyc();
      r0_valid = 0;
      r1_valid = 1; r1_we = 1; r1_addr = 2; r1_wdata = 32'h22222222;
      @(negedge clk); chk("seed2_rdy1", r1_ready, 1);
      cyc();

      // ---- contention: r0, r1, r0, r1 ----
      r0_valid = 1; r0_we = 0; r0_addr = 1;
      r1_valid = 1; r1_we = 0; r1_addr = 2;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("cont_rdy0", r0_ready, (c % 2 == 0));
         chk("cont_rdy1", r1_ready, (c % 2 == 1));
         cyc();
      end
      r1_valid = 0;

      // ---- write/read race; r0 alone first so the pointer favours r1 ----
      r0_addr = 1;
      @(negedge clk); chk("race_pre_rdy0", r0_ready, 1);
      cyc();
      r0_addr = 3;
      r1_valid = 1; r1_we = 1; r1_addr = 3; r1_wdata = 32'h12345678;
      @(negedge clk); chk("race_n_rdy1", r1_ready, 1); chk("race_n_rdy0", r0_ready, 0);
      cyc();
      r1_valid = 0;
      @(negedge clk); chk("race_n1_rdy0", r0_ready, 1);
      cyc();
      r0_valid = 0;
      @(negedge clk); chk("race_rd0", r0_rdata, 32'h12345678);
      cyc();

      // ---- clr mid-traffic ----
      r0_valid = 1; r0_we = 1; r0_addr = 9; r0_wdata = 32'hCAFEF00D;
      @(negedge clk); chk("clr_wr_rdy0", r0_ready, 1);
      cyc();
      r0_we = 0; clr = 1;
      @(negedge clk);
      chk("clr_rdy0", r0_ready, 0); chk("clr_rdy1", r1_ready, 0); chk("clr_mwe", m_we, 0);
      cyc();
      clr = 0;
      clear_exp();
      sweep_check("clr_sweep");
      chk("clr_post_rdy0", r0_ready, 1);
      cyc();
      r0_valid = 0;
      @(negedge clk); chk("clr_rd9", r0_rdata, 0);
      cyc();

      // ---- reset during sweep at address 7 ----
      clr = 1;
      cyc();
      clr = 0;
      clear_exp();
      for (int i = 0; i < 7; i++) cyc();
      @(negedge clk); chk("rsw_addr7", m_addr, 7);
      #1 rst = 1'b1;
      #1;
      chk("rsw_busy", busy, 1);
      chk("rsw_maddr", m_addr, 0);
      chk("rsw_rv0", r0_rvalid, 0);
      chk("rsw_rd0", r0_rdata, 0);
      chk("rsw_rd1", r1_rdata, 0);
      chk("rsw_rdy0", r0_ready, 0);
      cyc();
      cyc();
      rst = 1'b0;
      sweep_check("rsw_sweep");
      cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
